or_x16_checker: RTL and testbench

OR_X16_CHECKER -- requirements
Module: or_x16_checker

---
 rtl/or_x16_checker_if.sv | 31 +++
 rtl/or_x16_checker.sv | 159 +++++++++++++++
 tb/tb_or_x16_checker.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/or_x16_checker_if.sv
// Vector stream carried from the stimulus source into the OR-unit checker.
// The source drives operands, the observed response and the session marker;
// the checker answers with in_ready while it is collecting vectors.
interface or_x16_checker_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] dut_out;
  logic         last;

  modport master (
    output in_valid,
    output a,
    output b,
    output dut_out,
    output last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  dut_out,
    input  last,
    output in_ready
  );
endinterface

// File: rtl/or_x16_checker.sv
// Checker for a W-bit OR unit. A session opens on start and collects vectors
// until one tagged last. Each accepted vector is registered together with its
// index, then compared against a | b one cycle later. The checker counts
// vectors and mismatches (saturating) and keeps the index and bit mask of the
// first mismatch. A one-cycle FLUSH state lets the final in-flight vector
// retire before done/pass are raised.
module or_x16_checker #(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  or_x16_checker_if.slave     bus,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CW-1:0]       vec_count,
  output logic [CW-1:0]       err_count,
  output logic [CW-1:0]       first_fail_idx,
  output logic [W-1:0]        first_fail_mask
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t state;
  state_t state_next;

  logic          ready;
  logic          accept;
  logic          launch;

  logic          s1_valid;
  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_b;
  logic [W-1:0]  s1_out;
  logic [CW-1:0] s1_idx;

  logic [W-1:0]  expected;
  logic [W-1:0]  mask;
  logic          mismatch;

  assign bus.in_ready = ready;
  assign accept       = bus.in_valid && ready;
  assign launch       = start && ((state == IDLE) || (state == DONE));

  // State register; reset always returns to IDLE regardless of the clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Session sequencing and the state-decoded status outputs.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (accept && bus.last) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign pass = done && (err_count == '0);

  // Stage 1: capture each accepted vector and the index it was accepted at.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_out   <= '0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a   <= bus.a;
        s1_b   <= bus.b;
        s1_out <= bus.dut_out;
        s1_idx <= vec_count;
      end
    end
  end

  // Stage 2: reference OR result and the bits where the unit disagreed.
  always_comb begin
    expected = s1_a | s1_b;
    mask     = expected ^ s1_out;
    mismatch = |mask;
  end

  // Vector counter advances on the acceptance edge and sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_count <= '0;
    end else if (launch) begin
      vec_count <= '0;
    end else if (accept && (vec_count != CNT_MAX)) begin
      vec_count <= vec_count + CNT_ONE;
    end
  end

  // Error counter and first-failure record, updated as stage 2 retires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count       <= '0;
      first_fail_idx  <= '0;
      first_fail_mask <= '0;
    end else if (launch) begin
      err_count       <= '0;
      first_fail_idx  <= '0;
      first_fail_mask <= '0;
    end else if (s1_valid && mismatch) begin
      if (err_count != CNT_MAX) begin
        err_count <= err_count + CNT_ONE;
      end
      if (err_count == '0) begin
        first_fail_idx  <= s1_idx;
        first_fail_mask <= mask;
      end
    end
  end

endmodule

// File: tb/tb_or_x16_checker.sv
// Self-checking bench for or_x16_checker. Two instances share one stimulus
// stream: one with 8-bit counters and one with 4-bit counters so saturation
// is reachable in a short session. Expected results come from fixed session
// results and from a reference model that scans the vector queue.
module tb_or_x16_checker;

  logic clk = 1'b0;
  logic reset;
  logic start;

  always #5 clk = ~clk;

  or_x16_checker_if #(.W(16)) bus8 ();
  or_x16_checker_if #(.W(16)) bus4 ();

  logic        busy8, done8, pass8;
  logic [7:0]  vc8, ec8, fi8;
  logic [15:0] fm8;
  logic        busy4, done4, pass4;
  logic [3:0]  vc4, ec4, fi4;
  logic [15:0] fm4;

  or_x16_checker #(.W(16), .CW(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .bus             (bus8),
    .busy            (busy8),
    .done            (done8),
    .pass            (pass8),
    .vec_count       (vc8),
    .err_count       (ec8),
    .first_fail_idx  (fi8),
    .first_fail_mask (fm8)
  );

  or_x16_checker #(.W(16), .CW(4)) dut_sat (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .bus             (bus4),
    .busy            (busy4),
    .done            (done4),
    .pass            (pass4),
    .vec_count       (vc4),
    .err_count       (ec4),
    .first_fail_idx  (fi4),
    .first_fail_mask (fm4)
  );

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  logic [15:0] q_o[$];

  logic [31:0] got[16];
  logic [31:0] want[16];
  string       nm[16];

  // Drive the same vector onto both checker instances.
  task automatic set_bus(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] o, input logic l);
    bus8.in_valid = v; bus8.a = a; bus8.b = b; bus8.dut_out = o; bus8.last = l;
    bus4.in_valid = v; bus4.a = a; bus4.b = b; bus4.dut_out = o; bus4.last = l;
  endtask

  // Snapshot every observable output of both instances.
  task automatic capture();
    got[0]  = {31'b0, busy8};
    got[1]  = {31'b0, done8};
    got[2]  = {31'b0, pass8};
    got[3]  = {24'b0, vc8};
    got[4]  = {24'b0, ec8};
    got[5]  = {24'b0, fi8};
    got[6]  = {16'b0, fm8};
    got[7]  = {31'b0, bus8.in_ready};
    got[8]  = {31'b0, busy4};
    got[9]  = {31'b0, done4};
    got[10] = {31'b0, pass4};
    got[11] = {28'b0, vc4};
    got[12] = {28'b0, ec4};
    got[13] = {28'b0, fi4};
    got[14] = {16'b0, fm4};
    got[15] = {31'b0, bus4.in_ready};
  endtask

  // Fill one instance's expectations (base 0 = 8-bit counters, 8 = 4-bit).
  task automatic set_want(input int base, input logic bz, input logic dn, input logic ps,
                          input int vc, input int ec, input int fi, input int fm,
                          input logic rdy);
    want[base+0] = {31'b0, bz};
    want[base+1] = {31'b0, dn};
    want[base+2] = {31'b0, ps};
    want[base+3] = vc;
    want[base+4] = ec;
    want[base+5] = fi;
    want[base+6] = fm;
    want[base+7] = {31'b0, rdy};
  endtask

  // Reference model: walk the session queue, saturate counts at 2^cw-1.
  task automatic model(input int cw, output int ev, output int ee, output int ei,
                       output int em);
    int mx;
    int errs;
    bit seen;
    logic [15:0] m;
    mx   = (1 << cw) - 1;
    errs = 0;
    seen = 1'b0;
    ei   = 0;
    em   = 0;
    for (int i = 0; i < q_a.size(); i++) begin
      m = (q_a[i] | q_b[i]) ^ q_o[i];
      if (m != 16'h0) begin
        if (!seen) begin
          seen = 1'b1;
          ei   = (i > mx) ? mx : i;
          em   = int'(m);
        end
        errs++;
      end
    end
    ev = (q_a.size() > mx) ? mx : q_a.size();
    ee = (errs > mx) ? mx : errs;
  endtask

  // Expected DONE-state outputs of both instances from the model.
  task automatic want_done_from_model();
    int ev, ee, ei, em;
    model(8, ev, ee, ei, em);
    set_want(0, 1'b0, 1'b1, ee == 0, ev, ee, ei, em, 1'b0);
    model(4, ev, ee, ei, em);
    set_want(8, 1'b0, 1'b1, ee == 0, ev, ee, ei, em, 1'b0);
  endtask

  // Play the queued session; returns at the negedge where FLUSH is visible.
  task automatic drive_session(input bit do_start, input int max_gap);
    int gap;
    if (do_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < q_a.size(); i++) begin
      gap = (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
      for (int g = 0; g < gap; g++) begin
        set_bus(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        @(negedge clk);
      end
      set_bus(1'b1, q_a[i], q_b[i], q_o[i], i == q_a.size() - 1);
      @(negedge clk);
    end
    set_bus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic load_base();
    q_a = '{16'h0000, 16'h0110, 16'h01A4, 16'h00B7, 16'h9C48};
    q_b = '{16'h0000, 16'h0047, 16'h0491, 16'h1A27, 16'h0000};
    q_o = '{16'h0000, 16'h0157, 16'h05B5, 16'h1AB7, 16'h9C48};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    set_bus(1'b1, 16'h1234, 16'h0F0F, 16'h0000, 1'b1);
    #1 reset = 1'b1;
    #1 capture();
    set_want(0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    set_want(8, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (got[k] !== want[k]) begin
        miscompares++;
        $display("[TB] FAIL reset/%s got %0h want %0h", nm[k], got[k], want[k]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    set_bus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_all_match();
    load_base();
    drive_session(1'b1, 0);
    capture();
    set_want(0, 1'b1, 1'b0, 1'b0, 5, 0, 0, 0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (got[k] !== want[k]) begin
        miscompares++;
        $display("[TB] FAIL flush/%s got %0h want %0h", nm[k], got[k], want[k]);
      end
    end
    @(negedge clk);
    capture();
    set_want(0, 1'b0, 1'b1, 1'b1, 5, 0, 0, 0, 1'b0);
    set_want(8, 1'b0, 1'b1, 1'b1, 5, 0, 0, 0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (got[k] !== want[k]) begin
        miscompares++;
        $display("[TB] FAIL all_match/%s got %0h want %0h", nm[k], got[k], want[k]);
      end
    end
  endtask

  task automatic test_single_mismatch();
    load_base();
    q_o[3] = 16'h1AB6;
    drive_session(1'b1, 0);
    @(negedge clk);
    capture();
    set_want(0, 1'b0, 1'b1, 1'b0, 5, 1, 3, 16'h0001, 1'b0);
    set_want(8, 1'b0, 1'b1, 1'b0, 5, 1, 3, 16'h0001, 1'b0);
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (got[k] !== want[k]) begin
        miscompares++;
        $display("[TB] FAIL one_mismatch/%s got %0h want %0h", nm[k], got[k], want[k]);
      end
    end
  endtask

  task automatic test_first_fail_hold();
    load_base();
    q_o[1] = 16'h0057;
    q_o[4] = 16'h1C48;
    drive_session(1'b1, 1);
    @(negedge clk);
    capture();
    set_want(0, 1'b0, 1'b1, 1'b0, 5, 2, 1, 16'h0100, 1'b0);
    set_want(8, 1'b0, 1'b1, 1'b0, 5, 2, 1, 16'h0100, 1'b0);
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (got[k] !== want[k]) begin
        miscompares++;
        $display("[TB] FAIL two_mismatch/%s got %0h want %0h", nm[k], got[k], want[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    capture();
    set_want(0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    set_want(8, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (got[k] !== want[k]) begin
        miscompares++;
        $display("[TB] FAIL restart_clear/%s got %0h want %0h", nm[k], got[k], want[k]);
      end
    end
    q_a = '{16'h00F0, 16'hA000, 16'h0003};
    q_b = '{16'h0F00, 16'h0005, 16'h0000};
    q_o = '{16'h0FF0, 16'hA005, 16'h0003};
    drive_session(1'b0, 0);
    @(negedge clk);
    capture();
    set_want(0, 1'b0, 1'b1, 1'b1, 3, 0, 0, 0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (got[k] !== want[k]) begin
        miscompares++;
        $display("[TB] FAIL b2b_done/%s got %0h want %0h", nm[k], got[k], want[k]);
      end
    end
  endtask

  task automatic test_latency();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    set_bus(1'b1, 16'h0001, 16'h0002, 16'h0000, 1'b0);
    @(negedge clk);
    set_bus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    capture();
    set_want(0, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (got[k] !== want[k]) begin
        miscompares++;
        $display("[TB] FAIL accept_edge/%s got %0h want %0h", nm[k], got[k], want[k]);
      end
    end
    @(negedge clk);
    capture();
    set_want(0, 1'b1, 1'b0, 1'b0, 1, 1, 0, 16'h0003, 1'b1);
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (got[k] !== want[k]) begin
        miscompares++;
        $display("[TB] FAIL retire_edge/%s got %0h want %0h", nm[k], got[k], want[k]);
      end
    end
    set_bus(1'b1, 16'h0004, 16'h0000, 16'h0004, 1'b1);
    @(negedge clk);
    set_bus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    capture();
    set_want(0, 1'b0, 1'b1, 1'b0, 2, 1, 0, 16'h0003, 1'b0);
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (got[k] !== want[k]) begin
        miscompares++;
        $display("[TB] FAIL latency_done/%s got %0h want %0h", nm[k], got[k], want[k]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] flip;
    logic [15:0] first_flip;
    q_a.delete(); q_b.delete(); q_o.delete();
    first_flip = 16'h0;
    for (int i = 0; i < 20; i++) begin
      q_a.push_back(16'($urandom));
      q_b.push_back(16'($urandom));
      flip = 16'($urandom_range(16'hFFFF, 1));
      if (i == 0) first_flip = flip;
      q_o.push_back((q_a[i] | q_b[i]) ^ flip);
    end
    drive_session(1'b1, 1);
    @(negedge clk);
    capture();
    set_want(0, 1'b0, 1'b1, 1'b0, 20, 20, 0, int'(first_flip), 1'b0);
    set_want(8, 1'b0, 1'b1, 1'b0, 15, 15, 0, int'(first_flip), 1'b0);
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (got[k] !== want[k]) begin
        miscompares++;
        $display("[TB] FAIL saturate/%s got %0h want %0h", nm[k], got[k], want[k]);
      end
    end
  endtask

  task automatic test_reset_mid_session();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    set_bus(1'b1, 16'h0011, 16'h0100, 16'h0000, 1'b0);
    @(negedge clk);
    set_bus(1'b1, 16'h2200, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    set_bus(1'b1, 16'h0303, 16'h3030, 16'h3333, 1'b1);
    #1 reset = 1'b1;
    #1 capture();
    set_want(0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    set_want(8, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (got[k] !== want[k]) begin
        miscompares++;
        $display("[TB] FAIL mid_reset/%s got %0h want %0h", nm[k], got[k], want[k]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    set_bus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    repeat (3) @(negedge clk);
    capture();
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (got[k] !== want[k]) begin
        miscompares++;
        $display("[TB] FAIL post_reset/%s got %0h want %0h", nm[k], got[k], want[k]);
      end
    end
    q_a = '{16'h1000, 16'h0001, 16'h4444};
    q_b = '{16'h0200, 16'h0010, 16'h0000};
    q_o = '{16'h1200, 16'h0011, 16'h4454};
    drive_session(1'b1, 0);
    @(negedge clk);
    capture();
    want_done_from_model();
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (got[k] !== want[k]) begin
        miscompares++;
        $display("[TB] FAIL fresh_session/%s got %0h want %0h", nm[k], got[k], want[k]);
      end
    end
  endtask

  task automatic test_ignored_inputs();
    want_done_from_model();
    set_bus(1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1);
    repeat (3) @(negedge clk);
    set_bus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    capture();
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (got[k] !== want[k]) begin
        miscompares++;
        $display("[TB] FAIL valid_in_done/%s got %0h want %0h", nm[k], got[k], want[k]);
      end
    end
    q_a = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020};
    q_b = '{16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h1000, 16'h2000};
    q_o = '{16'h0101, 16'h0000, 16'h0404, 16'h0808, 16'h1010, 16'h2021};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < q_a.size(); i++) begin
      set_bus(1'b1, q_a[i], q_b[i], q_o[i], i == q_a.size() - 1);
      start = (i == 2 || i == 4);
      @(negedge clk);
      start = 1'b0;
    end
    set_bus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    capture();
    want_done_from_model();
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (got[k] !== want[k]) begin
        miscompares++;
        $display("[TB] FAIL start_in_run/%s got %0h want %0h", nm[k], got[k], want[k]);
      end
    end
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_bus(1'b1, 16'h00FF, 16'h0F00, 16'h0000, 1'b1);
    repeat (2) @(negedge clk);
    set_bus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    capture();
    set_want(0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    set_want(8, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (got[k] !== want[k]) begin
        miscompares++;
        $display("[TB] FAIL valid_in_idle/%s got %0h want %0h", nm[k], got[k], want[k]);
      end
    end
  endtask

  task automatic test_random_sessions();
    int len;
    logic [15:0] a, b, flip;
    for (int s = 0; s < 8; s++) begin
      q_a.delete(); q_b.delete(); q_o.delete();
      len = int'($urandom_range(20, 1));
      for (int i = 0; i < len; i++) begin
        a    = 16'($urandom);
        b    = 16'($urandom);
        flip = ($urandom_range(2, 0) == 0) ? 16'($urandom_range(16'hFFFF, 1)) : 16'h0;
        q_a.push_back(a);
        q_b.push_back(b);
        q_o.push_back((a | b) ^ flip);
      end
      drive_session(1'b1, 2);
      @(negedge clk);
      capture();
      want_done_from_model();
      for (int k = 0; k < 16; k++) begin
        vectors++;
        if (got[k] !== want[k]) begin
          miscompares++;
          $display("[TB] FAIL random%0d/%s got %0h want %0h", s, nm[k], got[k], want[k]);
        end
      end
    end
  endtask

  initial begin
    nm = '{"busy", "done", "pass", "vec_count", "err_count", "first_fail_idx",
           "first_fail_mask", "in_ready", "busy_cw4", "done_cw4", "pass_cw4",
           "vec_count_cw4", "err_count_cw4", "first_fail_idx_cw4",
           "first_fail_mask_cw4", "in_ready_cw4"};
    test_reset();
    test_all_match();
    test_single_mismatch();
    test_first_fail_hold();
    test_back_to_back();
    test_latency();
    test_saturation();
    test_reset_mid_session();
    test_ignored_inputs();
    test_random_sessions();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
